// File: rtl/icache_fill_pkg.sv
// Shared types and defaults for the instruction-cache line-fill engine.
package icache_fill_pkg;

    localparam int DEF_ADDR_WIDTH = 16;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_LINE_BITS  = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_STREAM = 2'd2
    } state_t;

    // Bits needed to hold values 0..max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/icache_fill_buf.sv
// Line buffer: one synchronous write port, one registered read port (1-cycle latency).
// Never stalls; the read register holds its value when rd_en is low.
module icache_fill_buf
    import icache_fill_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int LINE_BITS  = DEF_LINE_BITS
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [LINE_BITS-1:0]  wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [LINE_BITS-1:0]  rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int WORDS = 1 << LINE_BITS;

    logic [DATA_WIDTH-1:0] mem_q [WORDS];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Only the output register is reset so data_o comes up as zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem_q[rd_addr];
        end
    end

endmodule

// File: rtl/icache_fill.sv
// Line-fill engine: pipelined word reads (<= MAX_OUT in flight) into a buffer, then a gapless burst.
// Burst starts 2 cycles after the last return; read_i is dropped while full_o is high.
module icache_fill
    import icache_fill_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int LINE_BITS  = DEF_LINE_BITS,
    parameter int MAX_OUT    = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  read_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    output logic                  full_o,
    output logic                  ready_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  mem_req_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic                  mem_ack_i,
    input  logic                  mem_valid_i,
    input  logic [DATA_WIDTH-1:0] mem_data_i
);

    localparam int WORDS = 1 << LINE_BITS;
    localparam int CW    = LINE_BITS + 1;
    localparam int OW    = cnt_width(MAX_OUT);
    localparam int TW    = ADDR_WIDTH - LINE_BITS;

    localparam logic [CW-1:0] WORDS_C = CW'(WORDS);
    localparam logic [CW-1:0] LAST_C  = CW'(WORDS - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [OW-1:0] MAX_C   = OW'(MAX_OUT);
    localparam logic [OW-1:0] OUT_ONE = OW'(1);

    state_t          state_q, state_d;
    logic [TW-1:0]   line_q;
    logic [CW-1:0]   issued_q;
    logic [CW-1:0]   received_q;
    logic [CW-1:0]   stream_q;
    logic [OW-1:0]   outstanding_q;
    logic            ready_q;

    logic            start;
    logic            issue;
    logic            ret;
    logic            rd_en;
    logic            unused_addr_bits;

    assign unused_addr_bits = ^addr_i[LINE_BITS-1:0];

    // Returns outside FETCH, or with nothing in flight, are protocol errors and dropped.
    assign ret   = mem_valid_i && (state_q == ST_FETCH) && (outstanding_q != '0);
    assign issue = mem_req_o && mem_ack_i;

    always_comb begin
        state_d   = state_q;
        start     = 1'b0;
        rd_en     = 1'b0;
        mem_req_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (read_i) begin
                    start   = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                mem_req_o = (issued_q < WORDS_C) && (outstanding_q < MAX_C);
                if (ret && (received_q == LAST_C)) begin
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                // One extra cycle after the last read lets the final word leave the read register.
                rd_en = (stream_q < WORDS_C);
                if (stream_q == WORDS_C) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            line_q        <= '0;
            issued_q      <= '0;
            received_q    <= '0;
            stream_q      <= '0;
            outstanding_q <= '0;
            ready_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= rd_en;
            if (start) begin
                line_q        <= addr_i[ADDR_WIDTH-1:LINE_BITS];
                issued_q      <= '0;
                received_q    <= '0;
                stream_q      <= '0;
                outstanding_q <= '0;
            end else begin
                if (issue) begin
                    issued_q <= issued_q + CNT_ONE;
                end
                if (ret) begin
                    received_q <= received_q + CNT_ONE;
                end
                if (issue && !ret) begin
                    outstanding_q <= outstanding_q + OUT_ONE;
                end else if (!issue && ret) begin
                    outstanding_q <= outstanding_q - OUT_ONE;
                end
                if (rd_en) begin
                    stream_q <= stream_q + CNT_ONE;
                end
            end
        end
    end

    icache_fill_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .LINE_BITS  (LINE_BITS)
    ) u_buf (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (ret),
        .wr_addr (received_q[LINE_BITS-1:0]),
        .wr_data (mem_data_i),
        .rd_en   (rd_en),
        .rd_addr (stream_q[LINE_BITS-1:0]),
        .rd_data (data_o)
    );

    assign full_o     = (state_q != ST_IDLE);
    assign ready_o    = ready_q;
    assign mem_addr_o = (state_q == ST_FETCH) ? {line_q, issued_q[LINE_BITS-1:0]} : '0;

endmodule

// File: tb/tb_icache_fill.sv
// Bench for icache_fill: randomized memory responder plus a line-level reference model.
module tb_icache_fill;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int LB = 4;
    localparam int MO = 4;
    localparam int WORDS = 1 << LB;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          read_i = 1'b0;
    logic [AW-1:0] addr_i = '0;
    logic          full_o;
    logic          ready_o;
    logic [DW-1:0] data_o;
    logic          mem_req_o;
    logic [AW-1:0] mem_addr_o;
    logic          mem_ack_i = 1'b0;
    logic          mem_valid_i = 1'b0;
    logic [DW-1:0] mem_data_i = '0;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    int   ack_mode = 0;
    int   lat_min = 2;
    int   lat_max = 2;
    bit   junk_en = 1'b0;
    logic ack_now;
    logic [DW-1:0] salt = 32'h0;

    logic [AW-1:0] pend_addr[$];
    int            pend_due[$];
    logic [AW-1:0] iss_addr[$];
    int            iss_cyc[$];
    logic [DW-1:0] rx_dat[$];
    int            rx_cyc[$];
    int last_val_cyc = 0;
    int max_inflight = 0;
    int done_cyc = 0;

    icache_fill #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .LINE_BITS  (LB),
        .MAX_OUT    (MO)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .read_i      (read_i),
        .addr_i      (addr_i),
        .full_o      (full_o),
        .ready_o     (ready_o),
        .data_o      (data_o),
        .mem_req_o   (mem_req_o),
        .mem_addr_o  (mem_addr_o),
        .mem_ack_i   (mem_ack_i),
        .mem_valid_i (mem_valid_i),
        .mem_data_i  (mem_data_i)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Memory contents: a fixed function of the word address, perturbed by a per-run salt.
    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return {a ^ 16'h5A3C, ~a} ^ salt;
    endfunction

    // Memory responder: in-order returns, each no earlier than its own latency.
    initial begin
        forever begin
            @(negedge clock);
            if (reset) begin
                mem_ack_i   = 1'b0;
                mem_valid_i = 1'b0;
                pend_addr.delete();
                pend_due.delete();
            end else begin
                case (ack_mode)
                    0:       ack_now = 1'b1;
                    1:       ack_now = cyc[0];
                    default: ack_now = 1'($urandom_range(0, 1));
                endcase
                mem_ack_i = ack_now;
                if (mem_req_o === 1'b1 && ack_now) begin
                    pend_addr.push_back(mem_addr_o);
                    pend_due.push_back(cyc + int'($urandom_range(lat_min, lat_max)));
                    iss_addr.push_back(mem_addr_o);
                    iss_cyc.push_back(cyc);
                end
                mem_valid_i = 1'b0;
                mem_data_i  = $urandom;
                if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
                    mem_valid_i = 1'b1;
                    mem_data_i  = mem_word(pend_addr.pop_front());
                    void'(pend_due.pop_front());
                    last_val_cyc = cyc;
                end else if (junk_en && (ready_o === 1'b1 || full_o === 1'b0) && $urandom_range(0, 1) == 1) begin
                    mem_valid_i = 1'b1;
                end
                if (pend_addr.size() > max_inflight) max_inflight = pend_addr.size();
            end
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            if (ready_o === 1'b1) begin
                rx_dat.push_back(data_o);
                rx_cyc.push_back(cyc);
            end
        end
    end

    task automatic clear_logs();
        iss_addr.delete();
        iss_cyc.delete();
        rx_dat.delete();
        rx_cyc.delete();
        max_inflight = 0;
    endtask

    task automatic start_fill(input logic [AW-1:0] a);
        read_i = 1'b1;
        addr_i = a;
        @(negedge clock);
        read_i = 1'b0;
        addr_i = AW'($urandom);
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (full_o !== 1'b0 && n < 600) begin
            @(negedge clock);
            n++;
        end
        total++;
        if (full_o !== 1'b0) begin
            bad++;
            $display("FAIL %s_timeout: full_o=%b required 0 within 600 cycles", name, full_o);
        end
        done_cyc = cyc;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        read_i = 1'b1;
        addr_i = 16'h5555;
        repeat (3) begin
            @(negedge clock);
            total++;
            if ({full_o, ready_o, mem_req_o} !== 3'b000 || data_o !== '0 || mem_addr_o !== '0) begin
                bad++;
                $display("FAIL reset_outputs: full=%b ready=%b req=%b data=%h addr=%h required all 0",
                         full_o, ready_o, mem_req_o, data_o, mem_addr_o);
            end
        end
        reset  = 1'b0;
        read_i = 1'b0;
        @(negedge clock);
        total++;
        if (full_o !== 1'b0 || mem_req_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_read_held: full=%b req=%b required 0 0", full_o, mem_req_o);
        end
    endtask

    task automatic test_zero_wait();
        logic [AW-1:0] base = 16'h1230;
        int t0;
        ack_mode = 0; lat_min = 2; lat_max = 2;
        clear_logs();
        t0 = cyc;
        start_fill(16'h1237);
        total++;
        if (full_o !== 1'b1 || mem_req_o !== 1'b1 || mem_addr_o !== base) begin
            bad++;
            $display("FAIL zw_first_req: full=%b req=%b addr=%h required 1 1 %h", full_o, mem_req_o, mem_addr_o, base);
        end
        wait_done("zw");
        total++;
        if (iss_addr.size() != WORDS || iss_cyc[0] != t0 + 1 || iss_cyc[WORDS-1] != t0 + WORDS) begin
            bad++;
            $display("FAIL zw_issue_timing: count=%0d first=%0d last=%0d required %0d %0d %0d",
                     iss_addr.size(), iss_cyc[0], iss_cyc[WORDS-1], WORDS, t0 + 1, t0 + WORDS);
        end
        for (int k = 0; k < WORDS; k++) begin
            logic [AW-1:0] ea = base + AW'(k);
            total++;
            if (iss_addr[k] !== ea || rx_dat[k] !== mem_word(ea)) begin
                bad++;
                $display("FAIL zw_word%0d: addr=%h data=%h required %h %h", k, iss_addr[k], rx_dat[k], ea, mem_word(ea));
            end
        end
        total++;
        if (rx_dat.size() != WORDS || rx_cyc[0] != last_val_cyc + 2 || rx_cyc[WORDS-1] != rx_cyc[0] + WORDS - 1) begin
            bad++;
            $display("FAIL zw_burst: count=%0d first=%0d last=%0d required %0d %0d %0d",
                     rx_dat.size(), rx_cyc[0], rx_cyc[WORDS-1], WORDS, last_val_cyc + 2, last_val_cyc + WORDS + 1);
        end
        total++;
        if (done_cyc != rx_cyc[WORDS-1] + 1) begin
            bad++;
            $display("FAIL zw_full_drop: cycle=%0d required %0d", done_cyc, rx_cyc[WORDS-1] + 1);
        end
    endtask

    task automatic test_backpressure();
        logic [AW-1:0] a = AW'($urandom);
        logic [AW-1:0] base = {a[AW-1:LB], 4'h0};
        ack_mode = 1; lat_min = 10; lat_max = 10;
        clear_logs();
        start_fill(a);
        wait_done("bp");
        total++;
        if (max_inflight != MO) begin
            bad++;
            $display("FAIL bp_inflight: max=%0d required %0d", max_inflight, MO);
        end
        total++;
        if (iss_addr.size() != WORDS || rx_dat.size() != WORDS) begin
            bad++;
            $display("FAIL bp_counts: issues=%0d words=%0d required %0d %0d", iss_addr.size(), rx_dat.size(), WORDS, WORDS);
        end
        for (int k = 0; k < WORDS; k++) begin
            logic [AW-1:0] ea = base + AW'(k);
            total++;
            if (iss_addr[k] !== ea || rx_dat[k] !== mem_word(ea)) begin
                bad++;
                $display("FAIL bp_word%0d: addr=%h data=%h required %h %h", k, iss_addr[k], rx_dat[k], ea, mem_word(ea));
            end
        end
    endtask

    task automatic test_busy_drop();
        int n = 0;
        ack_mode = 0; lat_min = 3; lat_max = 3;
        clear_logs();
        start_fill(16'h2345);
        repeat (3) @(negedge clock);
        start_fill(16'h4000);
        while (ready_o !== 1'b1 && n < 200) begin
            @(negedge clock);
            n++;
        end
        start_fill(16'h4000);
        wait_done("busy_first");
        total++;
        if (iss_addr.size() != WORDS || rx_dat.size() != WORDS) begin
            bad++;
            $display("FAIL busy_counts: issues=%0d words=%0d required %0d %0d", iss_addr.size(), rx_dat.size(), WORDS, WORDS);
        end
        for (int k = 0; k < WORDS; k++) begin
            logic [AW-1:0] ea = 16'h2340 + AW'(k);
            total++;
            if (iss_addr[k] !== ea || rx_dat[k] !== mem_word(ea)) begin
                bad++;
                $display("FAIL busy_word%0d: addr=%h data=%h required %h %h", k, iss_addr[k], rx_dat[k], ea, mem_word(ea));
            end
        end
        clear_logs();
        start_fill(16'h4000);
        total++;
        if (full_o !== 1'b1 || mem_addr_o !== 16'h4000) begin
            bad++;
            $display("FAIL busy_reissue: full=%b addr=%h required 1 4000", full_o, mem_addr_o);
        end
        wait_done("busy_second");
        for (int k = 0; k < WORDS; k++) begin
            logic [AW-1:0] ea = 16'h4000 + AW'(k);
            total++;
            if (iss_addr[k] !== ea || rx_dat[k] !== mem_word(ea)) begin
                bad++;
                $display("FAIL busy2_word%0d: addr=%h data=%h required %h %h", k, iss_addr[k], rx_dat[k], ea, mem_word(ea));
            end
        end
    endtask

    task automatic test_reset_mid_fetch();
        int n = 0;
        ack_mode = 0; lat_min = 4; lat_max = 4;
        clear_logs();
        start_fill(16'h7770);
        while (iss_addr.size() < 5 && n < 50) begin
            @(negedge clock);
            n++;
        end
        reset = 1'b1;
        @(negedge clock);
        total++;
        if (mem_req_o !== 1'b0 || full_o !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_outputs: req=%b full=%b required 0 0", mem_req_o, full_o);
        end
        @(negedge clock);
        reset = 1'b0;
        repeat (20) @(negedge clock);
        total++;
        if (rx_dat.size() != 0) begin
            bad++;
            $display("FAIL rst_mid_no_ready: words=%0d required 0", rx_dat.size());
        end
        clear_logs();
        start_fill(16'h0010);
        wait_done("rst_mid");
        total++;
        if (iss_addr.size() != WORDS || rx_dat.size() != WORDS) begin
            bad++;
            $display("FAIL rst_mid_counts: issues=%0d words=%0d required %0d %0d", iss_addr.size(), rx_dat.size(), WORDS, WORDS);
        end
        for (int k = 0; k < WORDS; k++) begin
            logic [AW-1:0] ea = 16'h0010 + AW'(k);
            total++;
            if (iss_addr[k] !== ea || rx_dat[k] !== mem_word(ea)) begin
                bad++;
                $display("FAIL rst_mid_word%0d: addr=%h data=%h required %h %h", k, iss_addr[k], rx_dat[k], ea, mem_word(ea));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] bases [2] = '{16'hFFF0, 16'h0000};
        ack_mode = 0; lat_min = 2; lat_max = 2;
        for (int f = 0; f < 2; f++) begin
            int gap_cyc = done_cyc;
            clear_logs();
            start_fill(bases[f]);
            if (f == 1) begin
                total++;
                if (full_o !== 1'b1 || cyc != gap_cyc + 1) begin
                    bad++;
                    $display("FAIL b2b_gap: full=%b cycle=%0d required 1 %0d", full_o, cyc, gap_cyc + 1);
                end
            end
            wait_done("b2b");
            total++;
            if (iss_addr.size() != WORDS || rx_dat.size() != WORDS || rx_cyc[WORDS-1] != rx_cyc[0] + WORDS - 1) begin
                bad++;
                $display("FAIL b2b_counts%0d: issues=%0d words=%0d required %0d %0d unbroken", f, iss_addr.size(), rx_dat.size(), WORDS, WORDS);
            end
            for (int k = 0; k < WORDS; k++) begin
                logic [AW-1:0] ea = bases[f] + AW'(k);
                total++;
                if (iss_addr[k] !== ea || rx_dat[k] !== mem_word(ea)) begin
                    bad++;
                    $display("FAIL b2b%0d_word%0d: addr=%h data=%h required %h %h", f, k, iss_addr[k], rx_dat[k], ea, mem_word(ea));
                end
            end
        end
    endtask

    task automatic test_random();
        ack_mode = 2; lat_min = 1; lat_max = 8; junk_en = 1'b1;
        for (int f = 0; f < 4; f++) begin
            logic [AW-1:0] a = AW'($urandom);
            logic [AW-1:0] base = {a[AW-1:LB], 4'h0};
            salt = $urandom;
            clear_logs();
            start_fill(a);
            wait_done("rnd");
            total++;
            if (iss_addr.size() != WORDS || rx_dat.size() != WORDS || max_inflight > MO) begin
                bad++;
                $display("FAIL rnd%0d_counts: issues=%0d words=%0d inflight=%0d required %0d %0d <=%0d",
                         f, iss_addr.size(), rx_dat.size(), max_inflight, WORDS, WORDS, MO);
            end
            for (int k = 0; k < WORDS; k++) begin
                logic [AW-1:0] ea = base + AW'(k);
                total++;
                if (iss_addr[k] !== ea || rx_dat[k] !== mem_word(ea)) begin
                    bad++;
                    $display("FAIL rnd%0d_word%0d: addr=%h data=%h required %h %h", f, k, iss_addr[k], rx_dat[k], ea, mem_word(ea));
                end
            end
            repeat ($urandom_range(0, 3)) @(negedge clock);
        end
        junk_en = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_zero_wait();
        test_backpressure();
        test_busy_drop();
        test_reset_mid_fetch();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/icache_fill.md
# icache_fill

Line-fill engine between the instruction cache's memory port and the shared memory read port. It accepts one cache-line read request at a time and issues pipelined single-word reads to memory, honouring an outstanding-request limit. Returned words are captured into a local line buffer, and the completed line is streamed to the cache as one unbroken burst of `ready`/`data` cycles. This is the unbroken-burst delivery the instruction cache requires.

## Interface
Parameters:
- `ADDR_WIDTH`, default 16: word-address width on both sides.
- `DATA_WIDTH`, default 32: instruction word width.
- `LINE_BITS`, default 4: log2 of words per line (16 words).
- `MAX_OUT`, default 4: maximum memory reads in flight, range 1..8.

Ports:
- `clock`, in, 1: system clock. All logic is on the rising edge.
- `reset`, in, 1: synchronous, active-high.
- `read_i`, in, 1: line-fill request from the cache. Sampled only when `full_o` is low.
- `addr_i`, in, ADDR_WIDTH: word address of the miss. Bits [LINE_BITS-1:0] are ignored.
- `full_o`, out, 1: engine busy; new requests are dropped.
- `ready_o`, out, 1: `data_o` holds a valid line word.
- `data_o`, out, DATA_WIDTH: line word, delivered in order 0..2^LINE_BITS-1.
- `mem_req_o`, out, 1: memory read request.
- `mem_addr_o`, out, ADDR_WIDTH: word address for `mem_req_o`.
- `mem_ack_i`, in, 1: request accepted this cycle (while `mem_req_o` is high).
- `mem_valid_i`, in, 1: a read word is returned. Returns arrive in request order.
- `mem_data_i`, in, DATA_WIDTH: returned word.

## Operation
State machine: IDLE, FETCH, STREAM.

- **IDLE**
  - `full_o` is 0.
  - When `read_i` is 1: latch `line = addr_i[ADDR_WIDTH-1:LINE_BITS]`, clear the counters, go to FETCH.
- **FETCH**
  - `mem_req_o = (issued < 2^LINE_BITS) && (outstanding < MAX_OUT)`.
  - `mem_addr_o = {line, issued[LINE_BITS-1:0]}`.
  - A request issues on `mem_req_o && mem_ack_i`: `issued` and `outstanding` each increment.
  - On `mem_valid_i`: write `mem_data_i` to buffer[`received`], then `received` and `outstanding` increment/decrement.
  - When an issue and a return occur in the same cycle, `outstanding` is unchanged.
  - When the last word is received, go to STREAM.
- **STREAM**
  - Read the buffer sequentially, one word per cycle, with no gaps.
  - `ready_o` is high for exactly 2^LINE_BITS consecutive cycles, then go to IDLE.
- **Counter widths**
  - `issued` and `received` are LINE_BITS+1 bits.
  - `outstanding` is clog2(MAX_OUT+1) bits.
  - Counters saturate by construction and never wrap.
- `mem_valid_i` in IDLE or STREAM is a protocol error and is ignored. It must not corrupt the buffer.
- `mem_ack_i` while `mem_req_o` is low is ignored.
- Reset mid-operation: all state and counters clear, and the FSM goes to IDLE. The memory port shares `reset`, so no stale returns are expected.

## Timing
- Reset values of all outputs are 0: `full_o`, `ready_o`, `data_o`, `mem_req_o`, `mem_addr_o`.
- `read_i` is sampled at cycle t in IDLE:
  - `full_o` goes high at t+1.
  - The first `mem_req_o` is at t+1, combinational from FETCH state.
- `ready_o` and `data_o` are registered outputs. Let v be the cycle the last `mem_valid_i` is sampled:
  - `ready_o` is high for cycles v+2 .. v+2+2^LINE_BITS-1.
  - Word k appears at cycle v+2+k.
- `full_o` stays high through the final `ready_o` cycle and drops the cycle after.
- A `read_i` in that cycle (or later) is accepted.
- Minimum memory-side latency for a line is 2^LINE_BITS request cycles, plus memory latency, plus 2 cycles.

## Structure
- Package `icache_fill_pkg`:
  - state enum (IDLE/FETCH/STREAM);
  - default LINE_BITS, ADDR_WIDTH, DATA_WIDTH;
  - helper for counter widths.
- Sub-module `icache_fill_buf`: 2^LINE_BITS x DATA_WIDTH buffer, one synchronous write port and one synchronous read port (1-cycle read latency). The read register drives `data_o`.
- FSM and counters live in the top level.

## Test plan
1. **Reset values:** assert `reset` for 3 cycles → all outputs 0, `full_o` 0. Holding `read_i` during reset produces no `mem_req_o`.
2. **Zero-wait fill:** `mem_ack_i` tied to 1, `mem_valid_i` 2 cycles after each issue, `addr_i` 0x1237 →
   - `mem_addr_o` runs 0x1230..0x123F, one per cycle;
   - `ready_o` is high for 16 consecutive cycles;
   - `data_o` equals mem[0x1230..0x123F] in order.
3. **Back-pressure:** `mem_ack_i` toggling 1,0,1,0 and return latency of 10 cycles →
   - `outstanding` never exceeds MAX_OUT = 4 (checked by assertion);
   - all 16 words are still correct and in order.
4. **Busy requests dropped:** pulse `read_i` with `addr_i` 0x4000 during FETCH and again during STREAM → ignored, no extra memory requests. Re-issued on the cycle after `full_o` falls → a new fill of 0x4000..0x400F.
5. **Reset mid-FETCH:** `reset` asserted after 5 issues →
   - `mem_req_o` 0 and `full_o` 0 the next cycle;
   - no `ready_o` pulses;
   - a subsequent fill of 0x0010 is correct.
6. **Back-to-back fills:** 0xFFF0 (top line, address wrap boundary), then 0x0000 →
   - `mem_addr_o` never exceeds 0xFFFF;
   - both lines stream correctly with a 1-cycle IDLE gap.
